// File: rtl/datapath_pipe_if.sv
// ---------------------------------------------------------------------------
// datapath_pipe_if
//   Bundles the issue handshake, the decoded operation fields, and the
//   writeback/flag observation signals that pass between the control unit and
//   the datapath.
//
//   Parameters:
//     DW   - datapath width in bits
//     NREG - number of general registers (AW = $clog2(NREG))
//
//   Signals (direction as seen by the datapath / slave modport):
//     in_valid  in   operation presented by the control unit
//     in_ready  out  datapath can accept an operation this cycle
//     rs        in   source A register index
//     rt        in   source B register index / default destination
//     rd        in   alternate destination
//     regdes    in   0: dest=rt, 1: dest=rd
//     sel_srcb  in   0: srcB=reg[rt], 1: srcB=imm
//     imm       in   immediate operand
//     memtoreg  in   write mem_data instead of the ALU result
//     mem_data  in   load data, sampled at accept
//     alucs     in   ALU operation code
//     regwrite  in   write the destination at writeback
//     flagwrite in   update carry/zero flags
//     wb_valid  out  writeback stage holds a result this cycle
//     wb_rd     out  writeback destination
//     wb_data   out  writeback data
//     carry_flag out registered carry
//     zero_flag out  registered zero
//
//   Modports: master (control unit side), slave (datapath side).
// ---------------------------------------------------------------------------
interface datapath_pipe_if #(
  parameter int DW   = 8,
  parameter int NREG = 4
);
  localparam int AW = $clog2(NREG);

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] rs;
  logic [AW-1:0] rt;
  logic [AW-1:0] rd;
  logic          regdes;
  logic          sel_srcb;
  logic [DW-1:0] imm;
  logic          memtoreg;
  logic [DW-1:0] mem_data;
  logic [2:0]    alucs;
  logic          regwrite;
  logic          flagwrite;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          carry_flag;
  logic          zero_flag;

  modport master (
    output in_valid, rs, rt, rd, regdes, sel_srcb, imm, memtoreg, mem_data,
           alucs, regwrite, flagwrite,
    input  in_ready, wb_valid, wb_rd, wb_data, carry_flag, zero_flag
  );

  modport slave (
    input  in_valid, rs, rt, rd, regdes, sel_srcb, imm, memtoreg, mem_data,
           alucs, regwrite, flagwrite,
    output in_ready, wb_valid, wb_rd, wb_data, carry_flag, zero_flag
  );
endinterface

// File: rtl/datapath_pipe.sv
// ---------------------------------------------------------------------------
// datapath_pipe
//   Parametrised CPU datapath: register file, operand selection, ALU with a
//   registered carry/zero flag pair, a one-deep writeback stage, and a
//   multi-cycle shift-add multiplier. The control unit issues one operation
//   per accepted valid/ready handshake.
//
//   Ports:
//     clk    - system clock, all state updates on the rising edge
//     rst_n  - synchronous active-low reset
//     bus    - datapath_pipe_if.slave: issue handshake, operation fields,
//              writeback outputs and flags
//
//   Configuration macro:
//     DATAPATH_FWD_EN - when defined, register reads that hit the index held
//                       in a valid writeback stage return the writeback data,
//                       so back-to-back dependent operations see the new
//                       value. When undefined, reads return the register file
//                       contents and the control unit must leave one idle
//                       cycle between dependent operations.
// ---------------------------------------------------------------------------
module datapath_pipe #(
  parameter int DW   = 8,
  parameter int NREG = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  datapath_pipe_if.slave  bus
);

  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(DW);

  // ALU operation codes
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADC  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SHL1 = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  // Controller states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  // Architectural state
  logic [DW-1:0]   regFile_q [NREG];
  logic [0:0]      state_q,     state_d;
  logic            carry_q,     carry_d;
  logic            zero_q,      zero_d;

  // Writeback stage
  logic            wbValid_q,   wbValid_d;
  logic [AW-1:0]   wbRd_q,      wbRd_d;
  logic [DW-1:0]   wbData_q,    wbData_d;

  // Multiplier working registers
  logic [2*DW-1:0] mulAcc_q,    mulAcc_d;
  logic [2*DW-1:0] mulCand_q,   mulCand_d;
  logic [DW-1:0]   mulPlier_q,  mulPlier_d;
  logic [CW-1:0]   mulCount_q,  mulCount_d;

  // Fields of the multiply held until its result lands in writeback
  logic [AW-1:0]   mulDest_q,   mulDest_d;
  logic            mulRegWr_q,  mulRegWr_d;
  logic            mulFlagWr_q, mulFlagWr_d;
  logic            mulMemTo_q,  mulMemTo_d;
  logic [DW-1:0]   mulMemData_q, mulMemData_d;

  // Combinational helpers
  logic            accept;
  logic [AW-1:0]   issueDest;
  logic [DW-1:0]   regA;
  logic [DW-1:0]   regB;
  logic [DW-1:0]   opB;
  logic [DW:0]     addExt;
  logic [DW:0]     adcExt;
  logic [DW:0]     subExt;
  logic [DW-1:0]   aluRes;
  logic            aluCarry;
  logic [2*DW-1:0] mulSum;

  assign accept    = bus.in_valid && (state_q == ST_IDLE);
  assign issueDest = bus.regdes ? bus.rd : bus.rt;

  // Register read ports. With forwarding enabled, a read that matches the
  // index sitting in a valid writeback stage takes the writeback data, since
  // that value only reaches the register file on the coming edge.
  always_comb begin
    regA = regFile_q[bus.rs];
    regB = regFile_q[bus.rt];
`ifdef DATAPATH_FWD_EN
    if (wbValid_q && (wbRd_q == bus.rs)) begin
      regA = wbData_q;
    end
    if (wbValid_q && (wbRd_q == bus.rt)) begin
      regB = wbData_q;
    end
`endif
  end

  assign opB = bus.sel_srcb ? bus.imm : regB;

  // Extended arithmetic so the carry/borrow falls out as bit DW.
  assign addExt = {1'b0, regA} + {1'b0, opB};
  assign adcExt = addExt + {{DW{1'b0}}, carry_q};
  assign subExt = {1'b0, regA} - {1'b0, opB};

  // Single-cycle ALU. MUL is computed by the iterative multiplier, so it
  // falls to the default arm here and that value never reaches writeback.
  always_comb begin
    aluRes   = '0;
    aluCarry = 1'b0;
    case (bus.alucs)
      OP_ADD: begin
        aluRes   = addExt[DW-1:0];
        aluCarry = addExt[DW];
      end
      OP_ADC: begin
        aluRes   = adcExt[DW-1:0];
        aluCarry = adcExt[DW];
      end
      OP_SUB: begin
        aluRes   = subExt[DW-1:0];
        aluCarry = subExt[DW];
      end
      OP_AND:  aluRes = regA & opB;
      OP_OR:   aluRes = regA | opB;
      OP_XOR:  aluRes = regA ^ opB;
      OP_SHL1: begin
        aluRes   = {regA[DW-2:0], 1'b0};
        aluCarry = regA[DW-1];
      end
      default: begin
        aluRes   = '0;
        aluCarry = 1'b0;
      end
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier LSB is set.
  assign mulSum = mulAcc_q + (mulPlier_q[0] ? mulCand_q : '0);

  // Next-state logic. The writeback stage only stays valid for one cycle;
  // it is reloaded whenever a new result is produced and otherwise drops
  // its valid bit while keeping the last destination and data visible.
  always_comb begin
    state_d      = state_q;
    carry_d      = carry_q;
    zero_d       = zero_q;
    wbValid_d    = 1'b0;
    wbRd_d       = wbRd_q;
    wbData_d     = wbData_q;
    mulAcc_d     = mulAcc_q;
    mulCand_d    = mulCand_q;
    mulPlier_d   = mulPlier_q;
    mulCount_d   = mulCount_q;
    mulDest_d    = mulDest_q;
    mulRegWr_d   = mulRegWr_q;
    mulFlagWr_d  = mulFlagWr_q;
    mulMemTo_d   = mulMemTo_q;
    mulMemData_d = mulMemData_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.alucs == OP_MUL) begin
            state_d      = ST_MUL;
            mulAcc_d     = '0;
            mulCand_d    = {{DW{1'b0}}, regA};
            mulPlier_d   = opB;
            mulCount_d   = '0;
            mulDest_d    = issueDest;
            mulRegWr_d   = bus.regwrite;
            mulFlagWr_d  = bus.flagwrite;
            mulMemTo_d   = bus.memtoreg;
            mulMemData_d = bus.mem_data;
          end else begin
            wbValid_d = bus.regwrite;
            wbRd_d    = issueDest;
            wbData_d  = bus.memtoreg ? bus.mem_data : aluRes;
            if (bus.flagwrite) begin
              carry_d = aluCarry;
              zero_d  = (aluRes == '0);
            end
          end
        end
      end

      ST_MUL: begin
        mulAcc_d   = mulSum;
        mulCand_d  = {mulCand_q[2*DW-2:0], 1'b0};
        mulPlier_d = {1'b0, mulPlier_q[DW-1:1]};
        mulCount_d = mulCount_q + 1'b1;
        // Last of the DW steps: mulSum is the complete product.
        if (mulCount_q == CW'(DW - 1)) begin
          state_d   = ST_IDLE;
          wbValid_d = mulRegWr_q;
          wbRd_d    = mulDest_q;
          wbData_d  = mulMemTo_q ? mulMemData_q : mulSum[DW-1:0];
          if (mulFlagWr_q) begin
            carry_d = |mulSum[2*DW-1:DW];
            zero_d  = (mulSum[DW-1:0] == '0);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Control, flag, writeback-stage and multiplier registers. A reset in the
  // middle of a multiply returns to IDLE with writeback invalid, so the
  // partial product is simply dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
      wbValid_q    <= 1'b0;
      wbRd_q       <= '0;
      wbData_q     <= '0;
      mulAcc_q     <= '0;
      mulCand_q    <= '0;
      mulPlier_q   <= '0;
      mulCount_q   <= '0;
      mulDest_q    <= '0;
      mulRegWr_q   <= 1'b0;
      mulFlagWr_q  <= 1'b0;
      mulMemTo_q   <= 1'b0;
      mulMemData_q <= '0;
    end else begin
      state_q      <= state_d;
      carry_q      <= carry_d;
      zero_q       <= zero_d;
      wbValid_q    <= wbValid_d;
      wbRd_q       <= wbRd_d;
      wbData_q     <= wbData_d;
      mulAcc_q     <= mulAcc_d;
      mulCand_q    <= mulCand_d;
      mulPlier_q   <= mulPlier_d;
      mulCount_q   <= mulCount_d;
      mulDest_q    <= mulDest_d;
      mulRegWr_q   <= mulRegWr_d;
      mulFlagWr_q  <= mulFlagWr_d;
      mulMemTo_q   <= mulMemTo_d;
      mulMemData_q <= mulMemData_d;
    end
  end

  // Register file: written from the writeback stage one edge after the
  // result was latched, independently of whatever is being issued that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regFile_q[i] <= '0;
      end
    end else if (wbValid_q) begin
      regFile_q[wbRd_q] <= wbData_q;
    end
  end

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.wb_valid   = wbValid_q;
  assign bus.wb_rd      = wbRd_q;
  assign bus.wb_data    = wbData_q;
  assign bus.carry_flag = carry_q;
  assign bus.zero_flag  = zero_q;

endmodule

// File: doc/datapath_pipe.md
Name: datapath_pipe

Overview:
- Parametrised successor to the 8-bit single-cycle CPU datapath (regfile, operand muxes, ALU, carry/zero flag register).
- Generalised to DW-bit data and NREG registers.
- Adds a valid/ready issue handshake, a registered writeback stage, and a multi-cycle shift-add multiply.
- Sits between the control unit (decode, issue) and the memory interface; the control unit issues one operation per accepted handshake.

Parameters:
- DW, 8, datapath width in bits (>=4).
- NREG, 4, number of general registers (power of 2, >=2). Localparam AW = $clog2(NREG).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  datapath can accept; transfer when in_valid & in_ready.
- rs  input  AW  source A register index.
- rt  input  AW  source B register index / default destination.
- rd  input  AW  alternate destination.
- regdes  input  1  0: dest=rt, 1: dest=rd.
- sel_srcb  input  1  0: srcB=reg[rt], 1: srcB=imm.
- imm  input  DW  immediate operand.
- memtoreg  input  1  1: write mem_data instead of ALU result.
- mem_data  input  DW  load data, sampled at accept.
- alucs  input  3  ALU operation.
- regwrite  input  1  write destination at writeback.
- flagwrite  input  1  update carry/zero flags.
- wb_valid  output  1  writeback stage holds a result this cycle.
- wb_rd  output  AW  writeback destination.
- wb_data  output  DW  writeback data.
- carry_flag  output  1  registered carry.
- zero_flag  output  1  registered zero.

Behaviour:
- Reset (rst_n=0 at edge): all registers, flags, wb_valid, wb_rd and wb_data cleared to 0. FSM goes to IDLE. A multiply in progress is aborted and never written back.
- FSM states: IDLE and MUL. in_ready = (state==IDLE).
- ALU ops, results truncated to DW bits:
  - 000 ADD: carry = bit DW.
  - 001 ADC: A+B+carry_flag.
  - 010 SUB: A-B, carry = borrow (1 when A<B unsigned).
  - 011 AND, 100 OR, 101 XOR: carry = 0.
  - 110 SHL1: carry = A[DW-1].
  - 111 MUL: unsigned A*B, low DW bits kept; carry = 1 iff the high DW bits are nonzero.
- Zero flag = (ALU result == 0). Flags always derive from the ALU result, even when memtoreg=1.
- Non-MUL op accepted at edge E:
  - ALU result (or mem_data) and the destination are latched into the WB register at E.
  - If flagwrite=1, flags are updated at E, so the next operation's ADC sees them.
  - wb_valid=1 during cycle E..E+1; regfile written at edge E+1 when regwrite=1.
  - wb_valid reflects regwrite: a non-writing op yields wb_valid=0.
- MUL accepted at edge E:
  - Operands latched; state goes to MUL with an iteration counter of 0.
  - One shift-add step per cycle, DW steps total.
  - At edge E+DW: product into WB register, flags updated if flagwrite, state returns to IDLE.
  - Writeback at E+DW+1. in_ready=0 for cycles E..E+DW-1.
- Back-to-back issue: one op per cycle when no MUL is active.
- WB and read-port collision: the WB-stage write and a new op's read of the same index occur in the same cycle; resolution is defined under the optional feature.
- Regfile write and new-op latch happen on the same edge independently; WB stage is always overwritten by the next result.
- Register 0 is an ordinary writable register.
- in_valid while in_ready=0 is ignored; the control unit holds the operation until accepted.

Optional Feature:
- Macro DATAPATH_FWD_EN.
- Defined: a read of rs/rt equal to wb_rd while wb_valid=1 returns wb_data (forwarding); back-to-back dependent ops are correct.
- Undefined: reads return the regfile contents (stale value); the control unit must insert one idle cycle between dependent ops.

Test Plan:
- Reset: hold rst_n=0 two cycles mid-MUL -> all outputs 0, in_ready=1, no writeback after release.
- ADD then ADC, DW=8: reg1=0xF0, imm=0x20, ADD to reg2 with flagwrite -> reg2=0x10, carry=1, zero=0. Next ADC reg2+imm 0x00 -> 0x11.
- SUB equal: reg1=0x33 minus imm 0x33, flagwrite -> result 0x00, zero=1, carry=0. Then SUB 0x00-0x01 -> 0xFF, carry=1.
- MUL: 0x12*0x10 -> wb_data 0x20, carry=1. in_ready low exactly 8 cycles; an in_valid offered during busy is accepted only after in_ready returns to 1.
- Dependency: ADD r1=r0+imm 5, then ADD r2=r1+imm 1 on the next cycle -> with DATAPATH_FWD_EN r2=6; without it r2=1 (given r1 was 0 before).
- memtoreg: mem_data=0xA5, regdes=1, rd=3, flagwrite=0 -> reg3=0xA5, flags unchanged.
